// File: rtl/wordgen_pkg.sv
// Shared definitions for the serial word generator: FSM state codes,
// frame framing bit values and a constant-foldable ceil(log2) helper.
package wordgen_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  // ceil(log2(value)); returns 0 for value <= 1, same as $clog2
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level input. With PULSE=1 the
// output is a registered one-cycle pulse on each rising edge of the
// synchronised level; with PULSE=0 the output is the synchronised level.
module sync_edge #(
  parameter bit PULSE = 1'b1
) (
  input  logic clk,
  input  logic srst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic pulse_q;

  // Synchroniser chain plus edge-detect register
  always_ff @(posedge clk) begin
    if (srst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= d_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= sync_q & ~prev_q;
    end
  end

  assign q_o = PULSE ? pulse_q : sync_q;

endmodule

// File: rtl/wordgen_seq.sv
// Serial word generator: words keyed in on switches are committed into a
// small buffer and replayed as framed serial words (start bit, data MSB
// first, stop bit), once per play press or continuously in auto mode.
module wordgen_seq
  import wordgen_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 8,
  parameter int BIT_TICKS = 50
) (
  input  logic                         sysclk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             sw,
  input  logic                         write,
  input  logic                         play,
  input  logic                         auto,
  input  logic                         clear,
  output logic                         out,
  output logic                         busy,
  output logic [clog2(DEPTH+1)-1:0]    count,
  output logic                         full
);

  localparam int CNT_W  = clog2(DEPTH + 1);
  localparam int IDX_W  = clog2(DEPTH);
  localparam int TICK_W = (BIT_TICKS > 1) ? clog2(BIT_TICKS) : 1;
  localparam int BIT_W  = (WIDTH > 1) ? clog2(WIDTH) : 1;

  // ---- input synchronisation ----
  logic [2:0] btn_raw;
  logic [2:0] btn_pulse;
  logic       write_pulse, play_pulse, clear_pulse, auto_lvl;

  assign btn_raw = {clear, play, write};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      sync_edge #(.PULSE(1'b1)) u_sync (
        .clk  (sysclk),
        .srst (reset),
        .d_i  (btn_raw[gi]),
        .q_o  (btn_pulse[gi])
      );
    end
  endgenerate

  assign write_pulse = btn_pulse[0];
  assign play_pulse  = btn_pulse[1];
  assign clear_pulse = btn_pulse[2];

  sync_edge #(.PULSE(1'b0)) u_sync_auto (
    .clk  (sysclk),
    .srst (reset),
    .d_i  (auto),
    .q_o  (auto_lvl)
  );

  logic [WIDTH-1:0] sw_meta_q, sw_sync_q;

  // Switch bus synchroniser; only sampled at a write pulse, long after settling
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  // ---- buffer and word count ----
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic             write_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  // Count is frozen during playback, so the replayed range never moves
  assign write_ok = write_pulse && !clear_pulse && !busy && !full;

  // Word count: clear wins over a coincident write
  always_ff @(posedge sysclk) begin
    if (reset || clear_pulse) count_q <= '0;
    else if (write_ok)        count_q <= count_q + CNT_W'(1);
  end

  // Buffer write port (contents deliberately not reset)
  always_ff @(posedge sysclk) begin
    if (write_ok) mem[count_q[IDX_W-1:0]] <= sw_sync_q;
  end

  // ---- frame FSM ----
  logic [1:0]        state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [WIDTH-1:0]  shreg_q;
  logic              tick_last, load_sh, shift_sh;
  logic [CNT_W-1:0]  rd_idx_inc;

  assign tick_last  = (tick_q == TICK_W'(BIT_TICKS - 1));
  assign rd_idx_inc = CNT_W'(rd_idx_q) + CNT_W'(1);

  // State register
  always_ff @(posedge sysclk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath control; the buffer word is fetched on every
  // START entry using the read index being entered, so frames run gap-free
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    rd_idx_d = rd_idx_q;
    load_sh  = 1'b0;
    shift_sh = 1'b0;
    if (state_q != ST_IDLE) tick_d = tick_last ? '0 : tick_q + TICK_W'(1);
    case (state_q)
      ST_IDLE: begin
        if ((play_pulse || auto_lvl) && count_q != '0) begin
          state_d  = ST_START;
          rd_idx_d = '0;
          tick_d   = '0;
          load_sh  = 1'b1;
        end
      end
      ST_START: begin
        if (tick_last) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (tick_last) begin
          shift_sh = 1'b1;
          if (bit_q == BIT_W'(WIDTH - 1)) state_d = ST_STOP;
          else                            bit_d   = bit_q + BIT_W'(1);
        end
      end
      default: begin // ST_STOP
        if (tick_last) begin
          if (rd_idx_inc < count_q) begin
            state_d  = ST_START;
            rd_idx_d = rd_idx_q + IDX_W'(1);
            load_sh  = 1'b1;
          end else if (auto_lvl) begin
            state_d  = ST_START;
            rd_idx_d = '0;
            load_sh  = 1'b1;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
    endcase
    if (clear_pulse) begin
      state_d  = ST_IDLE;
      tick_d   = '0;
      bit_d    = '0;
      load_sh  = 1'b0;
      shift_sh = 1'b0;
    end
  end

  // Tick, bit and read-index counters
  always_ff @(posedge sysclk) begin
    if (reset) begin
      tick_q   <= '0;
      bit_q    <= '0;
      rd_idx_q <= '0;
    end else begin
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  // Shift register: registered buffer read on START entry, shifted per data bit
  always_ff @(posedge sysclk) begin
    if (reset)         shreg_q <= '0;
    else if (load_sh)  shreg_q <= mem[rd_idx_d];
    else if (shift_sh) shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
  end

  // Outputs decoded from registered state only
  always_comb begin
    busy = (state_q != ST_IDLE);
    case (state_q)
      ST_START: out = START_BIT;
      ST_DATA:  out = shreg_q[WIDTH-1];
      ST_STOP:  out = STOP_BIT;
      default:  out = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_wordgen_seq.sv
// Bench for wordgen_seq (WIDTH=4, DEPTH=4, BIT_TICKS=2): stimulus pushes the
// expected serial bits of each frame into a queue; a monitor pops one bit per
// busy cycle and compares it with out.
module tb_wordgen_seq;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int BT    = 2;
  localparam int WR = 0, PL = 1, CL = 2;

  logic             sysclk = 1'b0;
  logic             reset  = 1'b1;
  logic [WIDTH-1:0] sw     = '0;
  logic             write  = 1'b0;
  logic             play   = 1'b0;
  logic             auto   = 1'b0;
  logic             clear  = 1'b0;
  logic             out;
  logic             busy;
  logic [2:0]       count;
  logic             full;

  int total = 0;
  int bad   = 0;
  bit exp_q [$];

  wordgen_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BIT_TICKS(BT)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .sw     (sw),
    .write  (write),
    .play   (play),
    .auto   (auto),
    .clear  (clear),
    .out    (out),
    .busy   (busy),
    .count  (count),
    .full   (full)
  );

  always #5 sysclk = ~sysclk;

  // Monitor: one expected bit consumed per busy cycle
  always @(negedge sysclk) begin
    if (busy) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL extra_bit: out=%0b while busy, required no frame", out);
      end else begin
        bit e;
        e = exp_q.pop_front();
        if (out !== e) begin
          bad++;
          $display("FAIL serial_bit: out=%0b required=%0b (t=%0t)", out, e, $time);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  function automatic void push_frame(input logic [WIDTH-1:0] w);
    for (int t = 0; t < BT; t++) exp_q.push_back(1'b1);
    for (int b = WIDTH - 1; b >= 0; b--)
      for (int t = 0; t < BT; t++) exp_q.push_back(w[b]);
    for (int t = 0; t < BT; t++) exp_q.push_back(1'b0);
  endfunction

  task automatic press(input int which);
    case (which)
      WR:      write = 1'b1;
      PL:      play  = 1'b1;
      default: clear = 1'b1;
    endcase
    repeat (2) @(negedge sysclk);
    write = 1'b0;
    play  = 1'b0;
    clear = 1'b0;
    repeat (4) @(negedge sysclk);
  endtask

  task automatic write_word(input logic [WIDTH-1:0] w);
    sw = w;
    @(negedge sysclk);
    press(WR);
  endtask

  task automatic wait_busy(input logic lvl, input int limit, input string name);
    int n;
    n = 0;
    while (busy !== lvl && n < limit) begin
      @(negedge sysclk);
      n++;
    end
    total++;
    if (busy !== lvl) begin
      bad++;
      $display("FAIL %s: busy=%0b after %0d cycles, required=%0b", name, busy, n, lvl);
    end
  endtask

  initial begin
    // Reset and idle
    repeat (3) @(negedge sysclk);
    check("reset_out", out, 0);
    check("reset_busy", busy, 0);
    check("reset_count", count, 0);
    check("reset_full", full, 0);
    reset = 1'b0;
    press(PL);
    check("play_empty_busy", busy, 0);

    // Single write and play
    write_word(4'b1010);
    check("single_count", count, 1);
    push_frame(4'b1010);
    press(PL);
    wait_busy(1'b0, 100, "single_end");
    check("single_drained", exp_q.size(), 0);

    // Fill and overflow
    press(CL);
    check("clear_count", count, 0);
    write_word(4'h1);
    write_word(4'h2);
    write_word(4'h3);
    check("fill3_full", full, 0);
    write_word(4'h4);
    check("fill4_count", count, 4);
    check("fill4_full", full, 1);
    write_word(4'hF);
    check("overflow_count", count, 4);
    check("overflow_full", full, 1);
    push_frame(4'h1);
    push_frame(4'h2);
    push_frame(4'h3);
    push_frame(4'h4);
    press(PL);
    wait_busy(1'b0, 200, "fill_end");
    check("fill_drained", exp_q.size(), 0);

    // Auto loop, dropped during frame 0 of the second pass
    press(CL);
    write_word(4'h6);
    write_word(4'h9);
    check("auto_count", count, 2);
    push_frame(4'h6);
    push_frame(4'h9);
    push_frame(4'h6);
    push_frame(4'h9);
    auto = 1'b1;
    wait_busy(1'b1, 20, "auto_start");
    repeat (28) @(negedge sysclk);
    auto = 1'b0;
    wait_busy(1'b0, 200, "auto_end");
    repeat (10) @(negedge sysclk);
    check("auto_idle_busy", busy, 0);
    check("auto_drained", exp_q.size(), 0);

    // Clear mid-frame (during DATA)
    push_frame(4'h6);
    play = 1'b1;
    wait_busy(1'b1, 20, "clr_start");
    play = 1'b0;
    repeat (3) @(negedge sysclk);
    clear = 1'b1;
    repeat (4) @(negedge sysclk);
    check("clr_out", out, 0);
    check("clr_busy", busy, 0);
    check("clr_count", count, 0);
    exp_q.delete();
    clear = 1'b0;
    repeat (2) @(negedge sysclk);
    press(PL);
    check("clr_play_busy", busy, 0);

    // Write while busy, then reset during STOP
    write_word(4'h3);
    check("wb_count0", count, 1);
    push_frame(4'h3);
    play = 1'b1;
    wait_busy(1'b1, 20, "wb_start");
    play = 1'b0;
    sw = 4'hC;
    press(WR);
    check("wb_count", count, 1);
    repeat (4) @(negedge sysclk);
    reset = 1'b1;
    @(negedge sysclk);
    check("rst_out", out, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    exp_q.delete();
    reset = 1'b0;
    repeat (4) @(negedge sysclk);
    check("final_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wordgen_seq.md
# wordgen_seq

Parametrised serial word generator that succeeds the fixed 4-bit `wordgen`. Operators key words in on switches and commit them with `write` into a DEPTH-entry buffer. The block replays the buffer as framed serial words on `out`, either once per `play` press or continuously in auto mode. It sits between the board switch/button inputs and the single-pin serial output driving the downstream receiver/LED.

## Interface
Parameters:
- `WIDTH`, 4: bits per word (switch count).
- `DEPTH`, 8: buffer entries; power of two, ≥2.
- `BIT_TICKS`, 50: `sysclk` cycles per serial bit (1 µs at 50 MHz); ≥1.

Ports:
- `sysclk`  in  1  system clock, 50 MHz, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sw`  in  WIDTH  word value from switches; asynchronous.
- `write`  in  1  commit button; asynchronous level.
- `play`  in  1  single-pass playback button; asynchronous level.
- `auto`  in  1  continuous-loop mode; asynchronous level.
- `clear`  in  1  empty buffer and abort playback; asynchronous level.
- `out`  out  1  serial output.
- `busy`  out  1  high while a frame is being shifted.
- `count`  out  $clog2(DEPTH+1)  number of stored words.
- `full`  out  1  `count == DEPTH`.

## Operation
- **Synchronisation.** `write`, `play`, `auto` and `clear` each pass through a 2-FF synchroniser. `write`, `play` and `clear` are then rising-edge detected to give one-cycle pulses. `auto` is used as a synchronised level. `sw` is captured from a 2-FF synchronised copy at the moment of the write pulse.
- **Write.** On a write pulse with `!busy && !full`, store `sw` at `mem[count]` and increment `count`. A write pulse is ignored when `busy` or `full`.
- **Clear.** A clear pulse sets `count` to 0, aborts any frame, returns the FSM to IDLE and drives `out` to 0. If clear and write pulses coincide, clear wins.
- **Frame format.** Each frame is a start bit (1), then WIDTH data bits MSB first, then a stop bit (0). Every bit is held for exactly BIT_TICKS cycles. A frame is WIDTH+2 bits long.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START when (a play pulse arrives, or synced `auto` is high) and `count > 0`. The read index is set to 0.
  - START → DATA after BIT_TICKS cycles.
  - DATA → STOP after WIDTH bits.
  - STOP exit, taken after BIT_TICKS cycles:
    - If the read index < count−1: increment it and go to START, with no idle gap.
    - Else, if synced `auto` is high: wrap the read index to 0 and go to START.
    - Else: go to IDLE.
- **Auto deassert.** Dropping `auto` mid-pass finishes the current pass through the last stored word, then the FSM goes to IDLE.
- **Empty buffer.** With `count == 0`, `play` and `auto` are ignored and the FSM stays in IDLE.
- **Outputs.** `busy` is high in START, DATA and STOP. `out` is 0 in IDLE.
- **Reset values.** `out`=0, `busy`=0, `count`=0, `full`=0, FSM=IDLE, read index=0, tick and bit counters=0, synchroniser flops=0. Buffer contents are not reset.

## Timing
- **Input latency.** An input first sampled high at edge N produces its pulse in cycle N+2. The resulting effect (the `count` increment, `busy` rising, `out` going to 1) is registered and visible after edge N+3.
- **Frame length.** One frame occupies (WIDTH+2)·BIT_TICKS cycles. A single pass over k words occupies k·(WIDTH+2)·BIT_TICKS cycles. `busy` falls on the edge following the last STOP tick.
- **Tick counter.** Width is $clog2(BIT_TICKS). It wraps to 0 at BIT_TICKS−1 and advances the bit.
- **Play while busy.** A play pulse while `busy` is ignored; it is neither queued nor used to restart.
- **Bouncing.** Buttons are assumed debounced upstream. Every clean rising edge counts.

## Structure
- Shared package `wordgen_pkg` holds:
  - the state encoding localparams (IDLE, START, DATA, STOP);
  - `START_BIT`=1 and `STOP_BIT`=0;
  - a clog2 helper.
- The sub-module `sync_edge` is a 2-FF synchroniser with a registered rising-edge pulse output. It is instantiated once each for `write`, `play`, `auto` and `clear`; the `auto` instance uses the level output.
- Buffer storage is inferred distributed RAM with a registered read of `mem[rd_idx]` into the shift register at START entry.

## Test plan
All scenarios use WIDTH=4, DEPTH=4, BIT_TICKS=2.
- **Reset and idle.** Assert `reset` for 3 cycles → `out`=0, `busy`=0, `count`=0, `full`=0. A `play` press in this state keeps `busy`=0.
- **Single write and play.** Write `sw`=4'b1010, then press `play` → `count`=1. The next 12 cycles on `out` read 1,1 (start), 1,1,0,0,1,1,0,0 (data), 0,0 (stop). Then `busy`=0.
- **Fill and overflow.** Write 4'h1, 4'h2, 4'h3, 4'h4, then 4'hF → `count`=4 and `full`=1. A single pass outputs frames for 1, 2, 3, 4 back-to-back (48 cycles); 4'hF is never emitted.
- **Auto loop and deassert.** With 2 words stored, raise `auto` → frames repeat 0,1,0,1… Drop `auto` mid-frame 0 → frames 0 and 1 complete, then IDLE.
- **Clear mid-frame.** Press `clear` during DATA → 3 cycles later `out`=0, `busy`=0, `count`=0. A following `play` press is ignored.
- **Write while busy, and reset mid-frame.** A `write` press during playback leaves `count` unchanged. Asserting `reset` during STOP restores all reset values on the next edge.
